// File: rtl/eq_gain_mixer.sv
// Per-band gain stage with one shared multiplier, per-frame gain ramping and a saturated mix.
// Result latency N_BANDS+1 cycles from accept; the DONE state holds outputs until out_ready.
module eq_gain_mixer #(
    parameter int N_BANDS   = 8,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int GAIN_W    = 3,
    parameter int GAIN_FRAC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_BANDS*IN_W-1:0]   band_in,
    input  logic [N_BANDS-1:0]        band_en,
    input  logic [N_BANDS*GAIN_W-1:0] gain_tgt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_BANDS*OUT_W-1:0]  band_out,
    output logic [OUT_W-1:0]          mix_out,
    output logic [N_BANDS-1:0]        sat_flag,
    output logic                      mix_sat,
    output logic                      ramp_busy
);
    localparam int IW = $clog2(N_BANDS);
    localparam int KW = $clog2(N_BANDS + 1);
    localparam int PW = IN_W + GAIN_W + 1;
    localparam int SH = GAIN_FRAC + IN_W - OUT_W;
    localparam int AW = OUT_W + $clog2(N_BANDS);
    localparam logic [GAIN_W-1:0]       UNITY = GAIN_W'(1 << GAIN_FRAC);
    localparam logic signed [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] O_MIN = ~O_MAX;

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

    state_t                    r_state;
    logic [KW-1:0]             r_k;
    logic signed [IN_W-1:0]    r_band  [N_BANDS];
    logic [GAIN_W-1:0]         r_gain  [N_BANDS];
    logic [GAIN_W-1:0]         r_tgt   [N_BANDS];
    logic [N_BANDS-1:0]        r_en;
    logic signed [PW-1:0]      r_prod;
    logic signed [AW-1:0]      r_acc;
    logic signed [OUT_W-1:0]   r_work  [N_BANDS];
    logic                      r_swork [N_BANDS];
    logic signed [OUT_W-1:0]   r_bout  [N_BANDS];
    logic                      r_satf  [N_BANDS];
    logic signed [OUT_W-1:0]   r_mix;
    logic                      r_mix_sat;
    logic                      r_out_valid;
    logic                      r_busy;

    logic [IW-1:0]             w_ik, w_ck;
    logic signed [PW-1:0]      w_a, w_b, w_shf;
    logic signed [OUT_W-1:0]   w_val, w_mix;
    logic                      w_sat, w_mix_sat, w_busy;
    logic signed [AW-1:0]      w_acc;

    // Multiply band k this cycle; saturate/accumulate the product registered for band k-1.
    always_comb begin
        w_ik  = r_k[IW-1:0];
        w_ck  = IW'(r_k - KW'(1));
        w_a   = PW'(r_band[w_ik]);
        w_b   = PW'({1'b0, r_gain[w_ik]});
        w_shf = (w_a * w_b) >>> SH;
        w_val = r_prod[OUT_W-1:0];
        w_sat = 1'b0;
        if (r_prod > PW'(O_MAX)) begin
            w_val = O_MAX;
            w_sat = 1'b1;
        end else if (r_prod < PW'(O_MIN)) begin
            w_val = O_MIN;
            w_sat = 1'b1;
        end
        if (!r_en[w_ck]) begin
            w_val = '0;
            w_sat = 1'b0;
        end
        w_acc     = r_acc + AW'(w_val);
        w_mix     = w_acc[OUT_W-1:0];
        w_mix_sat = 1'b0;
        if (w_acc > AW'(O_MAX)) begin
            w_mix     = O_MAX;
            w_mix_sat = 1'b1;
        end else if (w_acc < AW'(O_MIN)) begin
            w_mix     = O_MIN;
            w_mix_sat = 1'b1;
        end
        w_busy = 1'b0;
        for (int i = 0; i < N_BANDS; i++) begin
            if (r_gain[i] != r_tgt[i]) w_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_en        <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < N_BANDS; i++) begin
                r_band[i]  <= '0;
                r_gain[i]  <= UNITY;
                r_tgt[i]   <= UNITY;
                r_work[i]  <= '0;
                r_swork[i] <= 1'b0;
                r_bout[i]  <= '0;
                r_satf[i]  <= 1'b0;
            end
        end else begin
            r_busy <= w_busy;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_BANDS; i++) begin
                            r_band[i] <= band_in[i*IN_W +: IN_W];
                            r_tgt[i]  <= gain_tgt[i*GAIN_W +: GAIN_W];
                        end
                        r_en    <= band_en;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_PROC;
                    end
                end
                S_PROC: begin
                    r_k <= r_k + KW'(1);
                    if (r_k < KW'(N_BANDS)) begin
                        r_prod <= w_shf;
                        if (r_gain[w_ik] < r_tgt[w_ik])
                            r_gain[w_ik] <= r_gain[w_ik] + GAIN_W'(1);
                        else if (r_gain[w_ik] > r_tgt[w_ik])
                            r_gain[w_ik] <= r_gain[w_ik] - GAIN_W'(1);
                    end
                    if (r_k != '0) begin
                        r_work[w_ck]  <= w_val;
                        r_swork[w_ck] <= w_sat;
                        r_acc         <= w_acc;
                    end
                    // Presented results change only here, so DONE outputs never move mid-frame.
                    if (r_k == KW'(N_BANDS)) begin
                        for (int i = 0; i < N_BANDS; i++) begin
                            r_bout[i] <= (IW'(i) == w_ck) ? w_val : r_work[i];
                            r_satf[i] <= (IW'(i) == w_ck) ? w_sat : r_swork[i];
                        end
                        r_mix       <= w_mix;
                        r_mix_sat   <= w_mix_sat;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign mix_out   = r_mix;
    assign mix_sat   = r_mix_sat;
    assign ramp_busy = r_busy;

    for (genvar g = 0; g < N_BANDS; g++) begin : g_out
        assign band_out[g*OUT_W +: OUT_W] = r_bout[g];
        assign sat_flag[g]                = r_satf[g];
    end
endmodule

// File: tb/tb_eq_gain_mixer.sv
// Bench for eq_gain_mixer: fixed vector table, hand sequences for reset/ramp/backpressure, random frames vs model.
module tb_eq_gain_mixer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] band_in = '0;
    logic [7:0]   band_en = '0;
    logic [23:0]  gain_tgt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] band_out;
    logic [15:0]  mix_out;
    logic [7:0]   sat_flag;
    logic         mix_sat;
    logic         ramp_busy;

    eq_gain_mixer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .band_in(band_in), .band_en(band_en), .gain_tgt(gain_tgt),
        .out_valid(out_valid), .out_ready(out_ready), .band_out(band_out),
        .mix_out(mix_out), .sat_flag(sat_flag), .mix_sat(mix_sat), .ramp_busy(ramp_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] bin;
        logic [7:0]   en;
        logic [23:0]  tgt;
        logic [127:0] ebout;
        logic [15:0]  emix;
        logic [7:0]   esat;
        logic         emsat;
    } vec_t;

    vec_t tbl[11];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: current gain of each band.
    int           mg[8];
    logic [127:0] m_bout;
    logic [15:0]  m_mix;
    logic [7:0]   m_sat;
    logic         m_msat;

    int           g_lat;
    logic [127:0] g_bout;
    logic [15:0]  g_mix;
    logic [7:0]   g_sat;
    logic         g_msat;
    logic         busy_tr[64];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mg[k] = 4;
    endtask

    task automatic model_frame(input logic [255:0] bin, input logic [7:0] en, input logic [23:0] tgt);
        longint x, s, sum;
        int     t;
        sum = 0; m_bout = '0; m_sat = '0;
        for (int k = 0; k < 8; k++) begin
            x = longint'($signed(bin[k*32 +: 32]));
            s = (x * longint'(mg[k])) >>> 18;
            if (en[k]) begin
                if (s > 32767)       begin s = 32767;  m_sat[k] = 1'b1; end
                else if (s < -32768) begin s = -32768; m_sat[k] = 1'b1; end
                m_bout[k*16 +: 16] = 16'(s);
                sum += s;
            end
            t = int'(tgt[k*3 +: 3]);
            if (mg[k] < t) mg[k] = mg[k] + 1;
            else if (mg[k] > t) mg[k] = mg[k] - 1;
        end
        m_msat = (sum > 32767) || (sum < -32768);
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        m_mix = 16'(sum);
    endtask

    // Called at a falling edge; returns at the falling edge after the output handshake.
    task automatic do_frame(input logic [255:0] bin, input logic [7:0] en, input logic [23:0] tgt);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 30) begin @(negedge clk); cnt++; end
        chk("in_ready_wait", 128'(in_ready), 128'(1));
        band_in = bin; band_en = en; gain_tgt = tgt; in_valid = 1'b1;
        model_frame(bin, en, tgt);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        busy_tr[0] = ramp_busy;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (cnt < 64) busy_tr[cnt] = ramp_busy;
        end
        g_lat = cnt; g_bout = band_out; g_mix = mix_out; g_sat = sat_flag; g_msat = mix_sat;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [255:0] rep(input logic [31:0] v);
        return {8{v}};
    endfunction

    initial begin
        logic [255:0] ramp_in, r_bin;
        logic [127:0] ramp_out, mask_out;
        logic [23:0]  t4, t7, tr;
        logic [7:0]   r_en;
        logic         seen;
        int           cnt;

        t4 = {8{3'd4}};
        t7 = {8{3'd7}};
        for (int k = 0; k < 8; k++) begin
            ramp_in[k*32 +: 32]  = 32'(k) << 16;
            ramp_out[k*16 +: 16] = 16'(k);
            mask_out[k*16 +: 16] = (k < 4) ? 16'd10 : 16'd0;
        end
        tbl[0] = '{ramp_in, 8'hFF, t4, ramp_out, 16'd28, 8'h00, 1'b0};
        tbl[1] = '{rep(32'h000A0000), 8'h0F, t4, mask_out, 16'd40, 8'h00, 1'b0};
        tbl[2] = '{rep(32'h7FFF0000), 8'hFF, t7, {8{16'h7FFF}}, 16'h7FFF, 8'h00, 1'b1};
        for (int i = 3; i < 6; i++)
            tbl[i] = '{rep(32'h7FFF0000), 8'hFF, t7, {8{16'h7FFF}}, 16'h7FFF, 8'hFF, 1'b1};
        tbl[6] = '{rep(32'h80000000), 8'hFF, t7, {8{16'h8000}}, 16'h8000, 8'hFF, 1'b1};
        for (int i = 7; i < 10; i++)
            tbl[i] = '{'0, 8'hFF, t4, '0, 16'd0, 8'h00, 1'b0};
        tbl[10] = '{ramp_in, 8'hFF, t4, ramp_out, 16'd28, 8'h00, 1'b0};
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ovalid", 128'(out_valid), 128'(0));
        chk("rst_outs", {band_out, mix_out, sat_flag, mix_sat, ramp_busy}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Reset in the middle of processing aborts the frame
        band_in = ramp_in; band_en = 8'hFF; gain_tgt = t4; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_outs", {out_valid, band_out, mix_out, sat_flag, mix_sat, ramp_busy}, '0);
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_ovalid", 128'(seen), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));

        // Fixed vector table
        for (int i = 0; i < 11; i++) begin
            do_frame(tbl[i].bin, tbl[i].en, tbl[i].tgt);
            chk($sformatf("tbl%0d_lat", i), 128'(g_lat), 128'(9));
            chk($sformatf("tbl%0d_bout", i), g_bout, tbl[i].ebout);
            chk($sformatf("tbl%0d_mix", i), 128'(g_mix), 128'(tbl[i].emix));
            chk($sformatf("tbl%0d_sat", i), 128'(g_sat), 128'(tbl[i].esat));
            chk($sformatf("tbl%0d_msat", i), 128'(g_msat), 128'(tbl[i].emsat));
        end

        // Gain ramp on band 0 toward 7
        tr = t4; tr[2:0] = 3'd7;
        for (int f = 0; f < 4; f++) begin
            do_frame({224'd0, 32'd100 << 16}, 8'hFF, tr);
            chk($sformatf("ramp%0d_b0", f), 128'(g_bout[15:0]), 128'(100 + 25 * f));
            if (f == 0) chk("ramp0_busy_rise", 128'(busy_tr[1]), 128'(1));
            if (f == 2) begin
                chk("ramp2_busy_e1", 128'(busy_tr[1]), 128'(1));
                chk("ramp2_busy_e2", 128'(busy_tr[2]), 128'(0));
            end
        end
        chk("ramp_busy_after", 128'(ramp_busy), 128'(0));

        // Backpressure: in_valid held high while results wait
        band_in = ramp_in; band_en = 8'hFF; gain_tgt = t4; in_valid = 1'b1;
        model_frame(ramp_in, 8'hFF, t4);
        @(posedge clk);
        @(negedge clk);
        band_in = rep(32'h12345678);
        cnt = 0;
        while (!out_valid && cnt < 50) begin @(negedge clk); cnt++; end
        chk("bp_lat", 128'(cnt), 128'(9));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_hold", i), {out_valid, in_ready, band_out, mix_out, sat_flag, mix_sat},
                {1'b1, 1'b0, m_bout, m_mix, m_sat, m_msat});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release", {126'd0, out_valid, in_ready}, 128'b01);
        repeat (3) @(negedge clk);
        chk("bp_no_accept", 128'(in_ready), 128'(1));

        // Random frames against the model
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 8; k++) begin
                r_bin[k*32 +: 32] = $urandom;
                tr[k*3 +: 3] = 3'($urandom_range(0, 7));
            end
            r_en = 8'($urandom);
            do_frame(r_bin, r_en, tr);
            chk($sformatf("rnd%0d_bout", i), g_bout, m_bout);
            chk($sformatf("rnd%0d_mix", i), 128'(g_mix), 128'(m_mix));
            chk($sformatf("rnd%0d_sat", i), 128'({g_sat, g_msat}), 128'({m_sat, m_msat}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
